signed_divider_seq: RTL and testbench
=====================================

Name: signed_divider_seq

Overview:
Sequential two's-complement divider, the inverse of the Booth multiplier datapath. It takes a 2*WIDTH-bit dividend (a product-width word) and a WIDTH-bit divisor. It returns a WIDTH-bit quotient and a WIDTH-bit remainder, one bit per cycle. It sits beside the multipliers as their check and undo path: dividing a multiplier product by one operand returns the other operand.

Parameters:
WIDTH, 4, operand and quotient width; the dividend is 2*WIDTH bits. Legal range 2..32.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  dividend and divisor are presented
in_ready  output  1  block is idle and can accept an operation
dividend  input  2*WIDTH  signed dividend
divisor  input  WIDTH  signed divisor
out_valid  output  1  result registers hold a valid result
out_ready  input  1  consumer takes the result
quotient  output  WIDTH  signed quotient, truncated toward zero
remainder  output  WIDTH  signed remainder; its sign follows the dividend
div_by_zero  output  1  divisor was 0
overflow  output  1  quotient not representable in WIDTH signed bits

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- On reset: state IDLE; in_ready=1; out_valid=0; quotient=0; remainder=0; div_by_zero=0; overflow=0; all internal registers cleared.
- Reset asserted mid-operation: the operation is abandoned. Nothing is output, and no partial result is retained.
- All outputs are registered.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid && in_ready (edge 0).
  - Latch the operand signs and magnitudes: |dividend| as 2*WIDTH-bit unsigned, |divisor| as WIDTH-bit unsigned. -2^(2W-1) and -2^(W-1) are handled exactly as unsigned magnitudes.
  - If divisor==0: go to DONE. div_by_zero=1, quotient=all ones, remainder=dividend[WIDTH-1:0], overflow=0. out_valid=1 after edge 1.
  - Else if |dividend|[2W-1:W] >= |divisor|: the magnitude quotient is >= 2^WIDTH. Go to DONE with overflow=1, quotient=0, remainder=0. out_valid=1 after edge 1.
  - Else go to CALC with iteration counter=0.
- CALC:
  - One restoring-division step per cycle, MSB first, on a (WIDTH+1)-bit partial remainder.
  - Shift left, trial-subtract |divisor|. If non-negative, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0.
  - Exactly WIDTH cycles (edges 1..WIDTH). The counter wraps to 0 on leaving CALC. Then go to FIX.
- FIX (edge WIDTH+1):
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend is negative.
  - overflow=1 if the magnitude quotient > 2^(W-1)-1 for a positive result, or > 2^(W-1) for a negative result. On overflow, quotient=0 and remainder=0.
  - Go to DONE with out_valid=1.
- Latency: normal results are visible WIDTH+1 edges after accept; zero-divisor and pre-check overflow results after 1 edge.
- DONE:
  - out_valid=1 and in_ready=0.
  - Outputs stay stable while out_ready=0.
  - On out_valid && out_ready: go to IDLE, out_valid=0, in_ready=1 on the next cycle. The result outputs keep their values until the next result is loaded.
- in_valid outside IDLE is ignored. There is no queuing.
- Invariant when no flag is set: dividend == quotient*divisor + remainder, and |remainder| < |divisor|.

Decomposition:
- Shared package fast_mult_pkg holds:
  - the state enum (IDLE, CALC, FIX, DONE);
  - the default WIDTH constant;
  - a function for the two's-complement magnitude.
- One sub-module: div_step. It is the combinational shift/trial-subtract/restore for one iteration, parameterised by WIDTH, and is instantiated once inside CALC.

Test Plan:
- dividend=8'sd42 (0x2A), divisor=6 -> after 5 edges: quotient=7, remainder=0, flags=0; in_ready low throughout.
- dividend=-43 (0xD5), divisor=6 -> quotient=-7 (0x9), remainder=-1 (0xF). dividend=-56 (0xC8), divisor=7 -> quotient=-8 (0x8), remainder=0.
- dividend=56, divisor=7 -> overflow=1, quotient=0, remainder=0 at edge 5 (FIX range check). dividend=100, divisor=3 -> overflow=1 at edge 1 (pre-check).
- dividend=0x5B, divisor=0 -> at edge 1: div_by_zero=1, quotient=0xF, remainder=0xB.
- out_ready held low 3 cycles after out_valid, with in_valid held high and new operands -> outputs stable, in_ready=0, new operands ignored. Release out_ready -> in_ready=1 on the next cycle, then the new operation is accepted.
- rst pulsed during the 2nd CALC cycle -> all outputs 0 and in_ready=1 immediately. A following 42/6 operation completes correctly with quotient=7.
- Random sweep of all 4-bit divisors with 256 dividends against a reference model (truncating division) -> all results match.

Source files
------------

// File: rtl/fast_mult_pkg.sv
// Shared types and helpers for the multiplier/divider family.
package fast_mult_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    // Two's-complement magnitude of a sign-extended value; the most negative value maps to its exact unsigned magnitude
    function automatic logic [63:0] tc_mag(input logic [63:0] x);
        return x[63] ? (~x + 64'd1) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, restore on borrow.
module div_step
    import fast_mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next_c,
    output logic             q_bit_c
);

    logic [WIDTH:0] shifted;

    assign shifted = {rem_in, bit_in};

    always_comb begin
        q_bit_c    = (shifted >= {1'b0, divisor});
        rem_next_c = WIDTH'(shifted);
        if (q_bit_c) begin
            rem_next_c = WIDTH'(shifted - {1'b0, divisor});
        end
    end

endmodule

// File: rtl/signed_divider_seq.sv
// Sequential signed divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per cycle.
module signed_divider_seq
    import fast_mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MAX = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic             dz_q, dz_d;
    logic             ovp_q, ovp_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] qsh_q, qsh_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] dvd_lo_q, dvd_lo_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic             overflow_q, overflow_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic [DW-1:0]    dvd_mag_c;
    logic [WIDTH-1:0] dvs_mag_c;
    logic [WIDTH-1:0] step_rem_c;
    logic             step_q_c;
    logic             fix_ov_c;

    assign dvd_mag_c = DW'(tc_mag(64'($signed(dividend))));
    assign dvs_mag_c = WIDTH'(tc_mag(64'($signed(divisor))));

    // Partial remainder stays below the divisor, so WIDTH bits hold it between steps
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in     (prem_q),
        .bit_in     (qsh_q[WIDTH-1]),
        .divisor    (dvs_q),
        .rem_next_c (step_rem_c),
        .q_bit_c    (step_q_c)
    );

    assign fix_ov_c = neg_q_q ? (qsh_q > NEG_MAX) : (qsh_q > POS_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            neg_q_q       <= 1'b0;
            neg_r_q       <= 1'b0;
            dz_q          <= 1'b0;
            ovp_q         <= 1'b0;
            prem_q        <= '0;
            qsh_q         <= '0;
            dvs_q         <= '0;
            dvd_lo_q      <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            neg_q_q       <= neg_q_d;
            neg_r_q       <= neg_r_d;
            dz_q          <= dz_d;
            ovp_q         <= ovp_d;
            prem_q        <= prem_d;
            qsh_q         <= qsh_d;
            dvs_q         <= dvs_d;
            dvd_lo_q      <= dvd_lo_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            overflow_q    <= overflow_d;
            out_valid_q   <= out_valid_d;
            in_ready_q    <= in_ready_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        neg_q_d       = neg_q_q;
        neg_r_d       = neg_r_q;
        dz_d          = dz_q;
        ovp_d         = ovp_q;
        prem_d        = prem_q;
        qsh_d         = qsh_q;
        dvs_d         = dvs_q;
        dvd_lo_d      = dvd_lo_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        overflow_d    = overflow_q;
        out_valid_d   = out_valid_q;
        in_ready_d    = in_ready_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    neg_r_d    = dividend[DW-1];
                    neg_q_d    = dividend[DW-1] ^ divisor[WIDTH-1];
                    dz_d       = (divisor == '0);
                    ovp_d      = (dvd_mag_c[DW-1:WIDTH] >= dvs_mag_c);
                    prem_d     = dvd_mag_c[DW-1:WIDTH];
                    qsh_d      = dvd_mag_c[WIDTH-1:0];
                    dvs_d      = dvs_mag_c;
                    dvd_lo_d   = dividend[WIDTH-1:0];
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                // Zero divisor and a quotient of 2^WIDTH or more finish on the first CALC edge
                if (dz_q) begin
                    div_by_zero_d = 1'b1;
                    overflow_d    = 1'b0;
                    quotient_d    = '1;
                    remainder_d   = dvd_lo_q;
                    out_valid_d   = 1'b1;
                    state_d       = DONE;
                end else if (ovp_q) begin
                    div_by_zero_d = 1'b0;
                    overflow_d    = 1'b1;
                    quotient_d    = '0;
                    remainder_d   = '0;
                    out_valid_d   = 1'b1;
                    state_d       = DONE;
                end else begin
                    prem_d = step_rem_c;
                    qsh_d  = {qsh_q[WIDTH-2:0], step_q_c};
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            FIX: begin
                div_by_zero_d = 1'b0;
                overflow_d    = fix_ov_c;
                quotient_d    = fix_ov_c ? '0 : (neg_q_q ? -qsh_q : qsh_q);
                remainder_d   = fix_ov_c ? '0 : (neg_r_q ? -prem_q : prem_q);
                out_valid_d   = 1'b1;
                state_d       = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_signed_divider_seq.sv
// Randomized and directed bench for signed_divider_seq against an arithmetic reference model.
module tb_signed_divider_seq;

    localparam int W  = 4;
    localparam int DW = 2 * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [W-1:0]  divisor = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          div_by_zero;
    logic          overflow;

    signed_divider_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        int           lat;
    } exp_t;

    exp_t expq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   busy = 0;
    bit   hs = 0;
    bit   have_res = 0;
    logic [W-1:0] held_q, held_r, last_q, last_r;
    logic         held_dz, held_ov, last_dz, last_ov;
    int           last_lat = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Truncating signed division with the range rules of the block
    function automatic exp_t model(input logic [DW-1:0] dvd, input logic [W-1:0] dvs);
        exp_t e;
        longint a, b, qt, rt, am, bm;
        a = longint'($signed(dvd));
        b = longint'($signed(dvs));
        e.dz = 1'b0; e.ov = 1'b0; e.q = '0; e.r = '0; e.lat = W + 1;
        if (b == 0) begin
            e.dz = 1'b1; e.q = '1; e.r = dvd[W-1:0]; e.lat = 1;
        end else begin
            am = (a < 0) ? -a : a;
            bm = (b < 0) ? -b : b;
            qt = a / b;
            rt = a % b;
            if (am / bm >= (64'sd1 <<< W)) e.lat = 1;
            if (qt > (64'sd1 <<< (W - 1)) - 1 || qt < -(64'sd1 <<< (W - 1))) begin
                e.ov = 1'b1;
            end else begin
                e.q = W'(qt);
                e.r = W'(rt);
            end
        end
        return e;
    endfunction

    // Accept and handshake tracking, sampled with pre-edge values
    always @(posedge clk) begin
        hs = out_valid && out_ready && !rst;
        if (!rst && in_valid && in_ready) begin
            acc_cyc = cyc;
            expq.push_back(model(dividend, divisor));
            busy = 1;
        end
        if (hs) busy = 0;
        cyc++;
    end

    // Output checker: new results against the model, stability while stalled, ready behaviour
    always @(negedge clk) begin
        if (!rst) begin
            if (hs) begin
                check("in_ready_after_take", in_ready, 1);
                check("out_valid_after_take", out_valid, 0);
                have_res = 0;
            end
            if (out_valid) begin
                if (!have_res) begin
                    if (expq.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_result: got out_valid=1 required no result pending");
                    end else begin
                        exp_t e;
                        e = expq.pop_front();
                        check("quotient", quotient, e.q);
                        check("remainder", remainder, e.r);
                        check("div_by_zero", div_by_zero, e.dz);
                        check("overflow", overflow, e.ov);
                        check("latency", cyc - acc_cyc - 1, e.lat);
                    end
                    held_q = quotient; held_r = remainder;
                    held_dz = div_by_zero; held_ov = overflow;
                    last_q = quotient; last_r = remainder;
                    last_dz = div_by_zero; last_ov = overflow;
                    last_lat = cyc - acc_cyc - 1;
                    have_res = 1;
                end else begin
                    check("stable_q", quotient, held_q);
                    check("stable_r", remainder, held_r);
                    check("stable_flags", {div_by_zero, overflow}, {held_dz, held_ov});
                end
                check("in_ready_done", in_ready, 0);
            end else if (busy) begin
                check("in_ready_busy", in_ready, 0);
            end
        end
    end

    task automatic op(input logic [DW-1:0] dvd, input logic [W-1:0] dvs,
                      input int hold, input bit keep_iv);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: got in_ready=0 required 1");
            return;
        end
        in_valid = 1'b1; dividend = dvd; divisor = dvs;
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 50) begin @(negedge clk); t++; end
        if (!out_valid) begin
            n_vec++; n_err++;
            $display("FAIL result_timeout: got out_valid=0 required 1");
            return;
        end
        repeat (hold) begin
            if (keep_iv) begin
                in_valid = 1'b1; dividend = DW'($urandom); divisor = W'($urandom);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (!keep_iv) in_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t m;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_q_r", {quotient, remainder}, 0);
        check("rst_flags", {div_by_zero, overflow}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Hand-computed pins on the model
        m = model(8'd42, 4'd6);
        check("model_42_6_q", m.q, 7);
        m = model(8'hD5, 4'd6);
        check("model_m43_6", {m.q, m.r}, 8'h9F);
        m = model(8'd100, 4'd3);
        check("model_100_3", {m.ov, 28'(m.lat)}, {1'b1, 28'd1});

        op(8'd42, 4'd6, 0, 0);
        check("d42_6", {last_q, last_r, last_dz, last_ov}, {4'd7, 4'd0, 2'b00});
        check("d42_6_lat", last_lat, 5);
        op(8'hD5, 4'd6, 0, 0);
        check("dm43_6", {last_q, last_r, last_dz, last_ov}, {4'h9, 4'hF, 2'b00});
        op(8'hC8, 4'd7, 0, 0);
        check("dm56_7", {last_q, last_r, last_dz, last_ov}, {4'h8, 4'h0, 2'b00});
        op(8'd56, 4'd7, 0, 0);
        check("d56_7_ovf", {last_q, last_r, last_dz, last_ov}, {4'h0, 4'h0, 2'b01});
        check("d56_7_lat", last_lat, 5);
        op(8'd100, 4'd3, 0, 0);
        check("d100_3_ovf", {last_q, last_r, last_dz, last_ov}, {4'h0, 4'h0, 2'b01});
        check("d100_3_lat", last_lat, 1);
        op(8'h5B, 4'd0, 0, 0);
        check("d5b_0_dz", {last_q, last_r, last_dz, last_ov}, {4'hF, 4'hB, 2'b10});
        check("d5b_0_lat", last_lat, 1);

        // Stall with new operands pending, then the pending operation goes through
        op(8'd42, 4'd6, 3, 1);
        op(8'hD5, 4'd6, 0, 0);
        check("after_stall", {last_q, last_r}, 8'h9F);

        // Reset during the second CALC cycle
        in_valid = 1'b1; dividend = 8'd42; divisor = 4'd6;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_outs", {quotient, remainder, div_by_zero, overflow}, 0);
        expq.delete();
        busy = 0;
        have_res = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        op(8'd42, 4'd6, 0, 0);
        check("post_rst_42_6", last_q, 7);

        // Every divisor with every dividend, in a randomly rotated order
        for (int dv = 0; dv < 16; dv++) begin
            int off;
            off = $urandom_range(255);
            for (int i = 0; i < 256; i++) begin
                op(DW'(i + off), W'(dv), $urandom_range(1), 0);
            end
        end

        repeat (3) @(negedge clk);
        check("pending_results", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
